wb_ctrl: RTL

//  Write-back sequencer for the core. Drives rd_mux select (rd_sel), reg_file write enable
//  and destination address, and stalls fetch/PC while a load waits for memory data.

---
 rtl/wb_ctrl_pkg.sv | 12 +
 rtl/wb_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/wb_ctrl_pkg.sv
// Shared write-back definitions: rd_mux source encodings used by both wb_ctrl and rd_mux,
// and the architectural register address width.
package wb_ctrl_pkg;

  localparam logic [1:0] RD_IMM  = 2'b00;
  localparam logic [1:0] RD_PCP4 = 2'b01;
  localparam logic [1:0] RD_ALU  = 2'b10;
  localparam logic [1:0] RD_MEM  = 2'b11;

  localparam int REG_ADDR_LEN = 5;

endpackage

// File: rtl/wb_ctrl.sv
// Write-back sequencer: drives rd_mux select and reg_file write port, stalls fetch while a
// load waits for memory. Optional load timeout/abort is enabled by defining WB_TIMEOUT_EN.
module wb_ctrl
  import wb_ctrl_pkg::*;
#(
  parameter int ADDR_W      = REG_ADDR_LEN,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic              wb_en_in,
  input  logic [1:0]        wb_src,
  input  logic [ADDR_W-1:0] rd_addr_in,
  input  logic              mem_rvalid,
  output logic [1:0]        rd_sel,
  output logic              rd_we,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              stall,
  output logic              wb_err
);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
  logic              wr_req;
  logic              ld_req;
  logic              tmo_hit;

  if (MEM_TIMEOUT < 2) begin : g_param_check
    $error("wb_ctrl: MEM_TIMEOUT must be at least 2");
  end

  assign wr_req = instr_valid && wb_en_in && (wb_src != RD_MEM);
  assign ld_req = instr_valid && wb_en_in && (wb_src == RD_MEM);

`ifdef WB_TIMEOUT_EN
  localparam int TMO_W = $clog2(MEM_TIMEOUT);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  assign tmo_hit = (tmo_cnt_q == TMO_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == IDLE) begin
      if (ld_req) begin
        tmo_cnt_d = '0;
      end
    end else if (!mem_rvalid) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ld_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      ld_addr_q <= ld_addr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ld_addr_d = ld_addr_q;
    unique case (state_q)
      IDLE: begin
        if (ld_req) begin
          state_d   = WAIT_MEM;
          ld_addr_d = rd_addr_in;
        end
      end
      WAIT_MEM: begin
        if (mem_rvalid || tmo_hit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset forces a quiet write port so a load caught mid-flight is dropped without a write.
  always_comb begin
    rd_sel  = RD_ALU;
    rd_we   = 1'b0;
    rd_addr = rd_addr_in;
    stall   = 1'b0;
    wb_err  = 1'b0;
    if (rst) begin
      rd_addr = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (wr_req) begin
            rd_sel = wb_src;
            rd_we  = (rd_addr_in != '0);
          end else if (ld_req) begin
            rd_sel = RD_MEM;
            stall  = 1'b1;
          end
        end
        WAIT_MEM: begin
          rd_sel  = RD_MEM;
          rd_addr = ld_addr_q;
          if (mem_rvalid) begin
            rd_we = (ld_addr_q != '0);
          end else if (tmo_hit) begin
            wb_err = 1'b1;
          end else begin
            stall = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
